// File: rtl/neuron_mac_seq.sv
// Time-multiplexed dense-layer neuron: one shared multiplier accumulates N_IN products onto a
// bias, then the sum is rescaled by an arithmetic right shift, clamped at zero and saturated.
module neuron_mac_seq #(
  parameter int unsigned N_IN    = 10,
  parameter int unsigned DW      = 8,
  parameter int unsigned WW      = 8,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned SHIFT   = 6,
  parameter int unsigned RELU_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DW-1:0]      a_flat,
  input  logic [N_IN*WW-1:0]      w_flat,
  input  logic [ACC_W-1:0]        bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DW-1:0]           out_data,
  output logic                    out_sat,
  output logic                    out_neg
);

  localparam int unsigned IdxW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned ProdW = DW + WW + 1;

  typedef enum logic [1:0] {StIdle, StMac, StFin, StOut} state_e;

  state_e                   state_q, state_d;
  logic [N_IN*DW-1:0]       a_q, a_d;
  logic [N_IN*WW-1:0]       w_q, w_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic                     out_valid_q, out_valid_d;
  logic [DW-1:0]            out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     out_neg_q, out_neg_d;

  logic [DW-1:0]            a_sel;
  logic [WW-1:0]            w_sel;
  logic signed [ProdW-1:0]  a_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, q_shift;
  logic                     acc_neg, q_over;

  always_comb begin
    a_sel    = a_q[idx_q*DW +: DW];
    w_sel    = w_q[idx_q*WW +: WW];
    // Both operands widened to the exact product width so the multiply is full precision.
    a_ext    = $signed({{WW{1'b0}}, 1'b0, a_sel});
    w_ext    = $signed({{(DW + 1){w_sel[WW-1]}}, w_sel});
    prod     = a_ext * w_ext;
    prod_ext = $signed({{(ACC_W - ProdW){prod[ProdW-1]}}, prod});
    q_shift  = acc_q >>> SHIFT;
    acc_neg  = acc_q[ACC_W-1];
    q_over   = |q_shift[ACC_W-1:DW];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    w_d         = w_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_neg_d   = out_neg_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_flat;
          w_d     = w_flat;
          acc_d   = $signed(bias);
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        if (idx_q == IdxW'(N_IN - 1)) begin
          idx_d   = '0;
          state_d = StFin;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFin: begin
        out_valid_d = 1'b1;
        state_d     = StOut;
        if (acc_neg) begin
          // Negatives clamp to zero and are flagged in either RELU mode.
          out_data_d = '0;
          out_neg_d  = (RELU_EN != 0) ? 1'b1 : 1'b1;
          out_sat_d  = 1'b0;
        end else if (q_over) begin
          out_data_d = '1;
          out_neg_d  = 1'b0;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = q_shift[DW-1:0];
          out_neg_d  = 1'b0;
          out_sat_d  = 1'b0;
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_neg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      w_q         <= w_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_neg_q   <= out_neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with hand-computed results at N_IN=10, DW=8, WW=8,
// ACC_W=24, SHIFT=6.
module tb_neuron_mac_seq;

  localparam int unsigned N_IN  = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned SHIFT = 6;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [N_IN*DW-1:0]     a_flat = '0;
  logic [N_IN*WW-1:0]     w_flat = '0;
  logic [ACC_W-1:0]       bias = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DW-1:0]          out_data;
  logic                   out_sat;
  logic                   out_neg;

  int checks = 0;
  int failures = 0;

  neuron_mac_seq #(
    .N_IN   (N_IN),
    .DW     (DW),
    .WW     (WW),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .RELU_EN(1)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_flat   (a_flat),
    .w_flat   (w_flat),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_neg  (out_neg)
  );

  always #5 clk = ~clk;

  // Offers one operand set, scrambles the inputs after acceptance, and counts edges to out_valid.
  task automatic run_op(input logic [N_IN*DW-1:0] a, input logic [N_IN*WW-1:0] w,
                        input logic [ACC_W-1:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    a_flat   = a;
    w_flat   = w;
    bias     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_flat   = ~a;
    w_flat   = ~w;
    bias     = ~b;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if ({out_data, out_sat, out_neg} !== 10'd0) begin
      failures++; $display("FAIL reset_outputs: got data=%0d sat=%b neg=%b expected 0 0 0",
                           out_data, out_sat, out_neg);
    end
  endtask

  task automatic test_zero_act();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    a = '0;
    for (int i = 0; i < N_IN; i++) w[i*WW +: WW] = 8'(8'h35 + 8'(i * 29));
    run_op(a, w, 24'd9, lat);
    checks++;
    if (lat !== 11) begin
      failures++; $display("FAIL zero_latency: got %0d expected 11", lat);
    end
    checks++;
    if ({out_data, out_sat, out_neg} !== 10'd0) begin
      failures++; $display("FAIL zero_result: got data=%0d sat=%b neg=%b expected 0 0 0",
                           out_data, out_sat, out_neg);
    end
    consume();
  endtask

  task automatic test_single_pos();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    a = '0; w = '0;
    a[0 +: DW] = 8'd64;
    w[0 +: WW] = 8'd127;
    run_op(a, w, 24'd0, lat);
    checks++;
    if (lat !== 11) begin
      failures++; $display("FAIL pos_latency: got %0d expected 11", lat);
    end
    checks++;
    if ({out_data, out_sat, out_neg} !== {8'd127, 2'b00}) begin
      failures++; $display("FAIL pos_result: got data=%0d sat=%b neg=%b expected 127 0 0",
                           out_data, out_sat, out_neg);
    end
    consume();
  endtask

  task automatic test_negative();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    a = '0; w = '0;
    a[0 +: DW] = 8'd100;
    w[0 +: WW] = 8'h80;
    run_op(a, w, 24'd9, lat);
    checks++;
    if ({out_data, out_sat, out_neg} !== {8'd0, 2'b01} || lat !== 11) begin
      failures++; $display("FAIL neg_result: got data=%0d sat=%b neg=%b lat=%0d expected 0 0 1 11",
                           out_data, out_sat, out_neg, lat);
    end
    consume();
  endtask

  task automatic test_saturate();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    for (int i = 0; i < N_IN; i++) begin
      a[i*DW +: DW] = 8'd255;
      w[i*WW +: WW] = 8'd127;
    end
    run_op(a, w, 24'd0, lat);
    checks++;
    if ({out_data, out_sat, out_neg} !== {8'd255, 2'b10} || lat !== 11) begin
      failures++; $display("FAIL sat_result: got data=%0d sat=%b neg=%b lat=%0d expected 255 1 0 11",
                           out_data, out_sat, out_neg, lat);
    end
    consume();
  endtask

  // A[i]=10(i+1), W alternates 5/-3: sum=1250-900=350, +1000 bias=1350, >>6 = 21.
  task automatic test_mixed();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    for (int i = 0; i < N_IN; i++) begin
      a[i*DW +: DW] = 8'(10 * (i + 1));
      w[i*WW +: WW] = (i % 2 == 0) ? 8'd5 : 8'hFD;
    end
    run_op(a, w, 24'd1000, lat);
    checks++;
    if ({out_data, out_sat, out_neg} !== {8'd21, 2'b00}) begin
      failures++; $display("FAIL mixed_result: got data=%0d sat=%b neg=%b expected 21 0 0",
                           out_data, out_sat, out_neg);
    end
    consume();
    // Last lane only: 200*64 - 12 = 12788, >>6 = 199.
    a = '0; w = '0;
    a[9*DW +: DW] = 8'd200;
    w[9*WW +: WW] = 8'd64;
    run_op(a, w, -24'sd12, lat);
    checks++;
    if ({out_data, out_sat, out_neg} !== {8'd199, 2'b00}) begin
      failures++; $display("FAIL last_lane_result: got data=%0d sat=%b neg=%b expected 199 0 0",
                           out_data, out_sat, out_neg);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    a = '0; w = '0;
    a[0 +: DW] = 8'd64;
    w[0 +: WW] = 8'd127;
    run_op(a, w, 24'd0, lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd127 || in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_cycle%0d: got valid=%b data=%0d in_ready=%b expected 1 127 0",
                             c, out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd127) begin
      failures++; $display("FAIL after_handshake: got in_ready=%b valid=%b data=%0d expected 1 0 127",
                           in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [N_IN*DW-1:0] a;
    logic [N_IN*WW-1:0] w;
    int lat;
    int seen;
    for (int i = 0; i < N_IN; i++) begin
      a[i*DW +: DW] = 8'd255;
      w[i*WW +: WW] = 8'd127;
    end
    a_flat = a; w_flat = w; bias = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0) begin
      failures++; $display("FAIL mid_reset_state: got in_ready=%b valid=%b data=%0d expected 1 0 0",
                           in_ready, out_valid, out_data);
    end
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL mid_reset_no_output: got %0d valid cycles expected 0", seen);
    end
    for (int i = 0; i < N_IN; i++) begin
      a[i*DW +: DW] = 8'(10 * (i + 1));
      w[i*WW +: WW] = (i % 2 == 0) ? 8'd5 : 8'hFD;
    end
    run_op(a, w, 24'd1000, lat);
    checks++;
    if ({out_data, out_sat, out_neg} !== {8'd21, 2'b00} || lat !== 11) begin
      failures++; $display("FAIL post_reset_op: got data=%0d sat=%b neg=%b lat=%0d expected 21 0 0 11",
                           out_data, out_sat, out_neg, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_zero_act();
    test_single_pos();
    test_negative();
    test_saturate();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
